// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and mul/div sequencer state encoding
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative shift-add multiplier / restoring divider owning HI/LO
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic             md_flush,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [1:0]       hilo_wr,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e          state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, m_q, m_d, dvd_q, dvd_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d;
    logic               sgn, sa, sb;
    logic [WIDTH:0]     msum, shl;
    logic [WIDTH+1:0]   dif;
    logic [WIDTH-1:0]   step_a, step_b, quo, rem;
    logic [2*WIDTH-1:0] prod;

    // One iteration step on the {a,b} pair, plus sign fixup of the final step
    // (a holds the product high half / partial remainder, b the multiplier / quotient)
    always_comb begin
        msum   = {1'b0, a_q} + (b_q[0] ? {1'b0, m_q} : '0);
        shl    = {a_q, b_q[WIDTH-1]};
        dif    = {1'b0, shl} - {2'b0, m_q};
        step_a = div_q ? (dif[WIDTH+1] ? shl[WIDTH-1:0] : dif[WIDTH-1:0]) : msum[WIDTH:1];
        step_b = div_q ? {b_q[WIDTH-2:0], ~dif[WIDTH+1]} : {msum[0], b_q[WIDTH-1:1]};
        prod   = neg_q ? -{step_a, step_b} : {step_a, step_b};
        quo    = (m_q == '0) ? '1 : (neg_q ? -step_b : step_b);
        rem    = (m_q == '0) ? dvd_q : (rneg_q ? -step_a : step_a);
        sgn    = (md_op == MD_MULT) || (md_op == MD_DIV);
        sa     = sgn & op1[WIDTH-1];
        sb     = sgn & op2[WIDTH-1];
    end

    // Next-state: operand capture, iteration, flush and HI/LO updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        dvd_d   = dvd_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = (state_q != ST_RUN && hilo_wr[1]) ? hilo_wdata : hi_q;
        lo_d    = (state_q != ST_RUN && hilo_wr[0]) ? hilo_wdata : lo_q;
        case (state_q)
            ST_RUN: begin
                a_d   = step_a;
                b_d   = step_b;
                cnt_d = cnt_q + 1'b1;
                if (md_flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    hi_d    = div_q ? rem : prod[2*WIDTH-1:WIDTH];
                    lo_d    = div_q ? quo : prod[WIDTH-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (md_start && !md_flush) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    a_d     = '0;
                    b_d     = sa ? -op1 : op1;
                    m_d     = sb ? -op2 : op2;
                    dvd_d   = op1;
                    div_d   = (md_op == MD_DIV) || (md_op == MD_DIVU);
                    neg_d   = sa ^ sb;
                    rneg_d  = sa;
                end
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            dvd_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            dvd_q   <= dvd_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign md_busy = (state_q == ST_RUN);
    assign md_done = (state_q == ST_DONE);
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: rtl/alu_md.sv
// alu_md: execute-stage ALU with combinational datapath and sequential mul/div unit
module alu_md
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [SHW-1:0]   shamt,
    input  logic [3:0]       alu_control,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic             md_flush,
    input  logic [1:0]       hilo_wr,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] sum, diff;

    // Combinational ALU; undefined codes give 0 so nothing latches
    always_comb begin
        sum  = op1 + op2;
        diff = op1 - op2;
        case (alu_control)
            ALU_AND:  result = op1 & op2;
            ALU_OR:   result = op1 | op2;
            ALU_ADD:  result = sum;
            ALU_XOR:  result = op1 ^ op2;
            ALU_SUB:  result = diff;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, op1 < op2};
            ALU_SLL:  result = op2 << shamt;
            ALU_SRL:  result = op2 >> shamt;
            ALU_SRA:  result = $signed(op2) >>> shamt;
            ALU_NOR:  result = ~(op1 | op2);
            default:  result = '0;
        endcase
        overflow = (alu_control == ALU_ADD) ? (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]) :
                   (alu_control == ALU_SUB) ? (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]) :
                   1'b0;
    end

    assign zero = (result == '0);

    alu_muldiv_seq #(
        .WIDTH(WIDTH),
        .SHW  (SHW)
    ) u_md (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start),
        .md_op     (md_op),
        .md_flush  (md_flush),
        .op1       (op1),
        .op2       (op2),
        .hilo_wr   (hilo_wr),
        .hilo_wdata(hilo_wdata),
        .md_busy   (md_busy),
        .md_done   (md_done),
        .hi        (hi),
        .lo        (lo)
    );

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: randomized scoreboard bench for alu_md against a behavioural model
module tb_alu_md;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] op1, op2, result, hilo_wdata, hi, lo;
    logic [4:0]  shamt;
    logic [3:0]  alu_control;
    logic        zero, overflow, md_start, md_flush, md_busy, md_done;
    logic [1:0]  md_op, hilo_wr;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] mhi = 0, mlo = 0;

    always #5 clk = ~clk;

    alu_md #(.WIDTH(32), .SHW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .op1        (op1),
        .op2        (op2),
        .shamt      (shamt),
        .alu_control(alu_control),
        .result     (result),
        .zero       (zero),
        .overflow   (overflow),
        .md_start   (md_start),
        .md_op      (md_op),
        .md_flush   (md_flush),
        .hilo_wr    (hilo_wr),
        .hilo_wdata (hilo_wdata),
        .md_busy    (md_busy),
        .md_done    (md_done),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    function automatic logic [33:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] s);
        longint sa, sb, t, lim;
        logic [31:0] r;
        logic ov;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lim = 64'sd2147483647;
        ov  = 1'b0;
        t   = 0;
        case (c)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: begin t = sa + sb; r = 32'(t); ov = (t > lim) || (t < -lim - 1); end
            4'h3: r = a ^ b;
            4'h6: begin t = sa - sb; r = 32'(t); ov = (t > lim) || (t < -lim - 1); end
            4'h7: r = (sa < sb) ? 32'd1 : 32'd0;
            4'h8: r = (a < b) ? 32'd1 : 32'd0;
            4'h9: r = b << s;
            4'hA: r = b >> s;
            4'hB: r = 32'(sb >>> s);
            4'hC: r = ~(a | b);
            default: r = 32'd0;
        endcase
        return {r, r == 32'd0, ov};
    endfunction

    function automatic logic [63:0] md_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ua, ub;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            2'b10: begin q = 32'(sa / sb); r = 32'(sa % sb); return {r, q}; end
            default: begin q = 32'(ua / ub); r = 32'(ua % ub); return {r, q}; end
        endcase
    endfunction

    task automatic alu_chk(input string nm, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] s);
        alu_control = c;
        op1 = a;
        op2 = b;
        shamt = s;
        #1;
        chk(nm, {result, zero, overflow}, alu_ref(c, a, b, s));
    endtask

    task automatic md_go(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
        logic [63:0] e;
        md_op = op;
        op1 = a;
        op2 = b;
        md_start = 1'b1;
        if (push) begin
            e = md_ref(op, a, b);
            exp_q.push_back(e);
            {mhi, mlo} = e;
        end
        @(posedge clk);
        #1;
        md_start = 1'b0;
    endtask

    task automatic wait_done(input bit poke);
        int nb;
        bit got;
        nb = 0;
        got = 0;
        for (int n = 1; n <= 100 && !got; n++) begin
            @(negedge clk);
            if (md_done) begin
                got = 1;
                chk("done_cycle", 66'(n), 66'd33);
                chk("busy_cycles", 66'(nb), 66'd32);
            end else if (md_busy) begin
                nb++;
            end
            if (poke && n == 5) begin
                md_start = 1'b1;
                md_op = 2'b11;
                op1 = $urandom;
                op2 = $urandom;
                hilo_wr = 2'b11;
                hilo_wdata = 32'hDEAD_BEEF;
            end
            if (poke && n == 6) begin
                md_start = 1'b0;
                hilo_wr = 2'b00;
            end
        end
        if (!got) chk("done_timeout", 66'd0, 66'd1);
    endtask

    // Monitor: every md_done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && md_done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 66'd1, 66'd0);
            end else begin
                chk("md_result", {2'b0, hi, lo}, {2'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int nd;
        logic [1:0] rop;
        logic [31:0] ra, rb;
        reset = 1'b1;
        md_start = 1'b0;
        md_op = 2'b00;
        md_flush = 1'b0;
        hilo_wr = 2'b00;
        hilo_wdata = 32'd0;
        op1 = 32'd0;
        op2 = 32'd0;
        shamt = 5'd0;
        alu_control = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_state", {hi, lo, md_busy, md_done}, 66'd0);

        alu_chk("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0);
        chk("add_ovf_const", {32'd0, result, zero, overflow}, {32'd0, 32'h8000_0000, 1'b0, 1'b1});
        alu_chk("sub_zero", 4'b0110, 32'd5, 32'd5, 5'd0);
        chk("sub_zero_const", {32'd0, result, zero, overflow}, {32'd0, 32'h0, 1'b1, 1'b0});
        alu_chk("undef_code", 4'b0100, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
        chk("undef_const", {32'd0, result}, 66'd0);
        alu_chk("slt", 4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0);
        chk("slt_const", {32'd0, result}, 66'd1);
        alu_chk("sltu", 4'b1000, 32'hFFFF_FFFF, 32'h1, 5'd0);
        chk("sltu_const", {32'd0, result}, 66'd0);
        alu_chk("sra", 4'b1011, 32'h0, 32'h8000_0000, 5'd4);
        chk("sra_const", {32'd0, result}, {34'd0, 32'hF800_0000});
        alu_chk("sub_ovf", 4'b0110, 32'h8000_0000, 32'h1, 5'd0);
        for (int i = 0; i < 60; i++) begin
            alu_chk("alu_rand", 4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom));
        end
        @(negedge clk);

        md_go(2'b00, 32'hFFFF_FFFD, 32'd5, 1);
        wait_done(0);
        chk("mult_const", {2'b0, hi, lo}, {2'b0, 64'hFFFF_FFFF_FFFF_FFF1});
        md_go(2'b01, 32'hFFFF_FFFF, 32'd2, 1);
        wait_done(0);
        chk("multu_const", {2'b0, hi, lo}, {2'b0, 64'h0000_0001_FFFF_FFFE});
        md_go(2'b10, 32'hFFFF_FFF9, 32'd2, 1);
        wait_done(0);
        chk("div_const", {2'b0, hi, lo}, {2'b0, 64'hFFFF_FFFF_FFFF_FFFD});
        md_go(2'b11, 32'd5, 32'd0, 1);
        wait_done(0);
        chk("divu0_const", {2'b0, hi, lo}, {2'b0, 64'h0000_0005_FFFF_FFFF});

        md_go(2'b00, 32'd12345, 32'hFFFF_FFB3, 1);
        wait_done(1);

        md_go(2'b01, $urandom, $urandom, 0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        md_flush = 1'b1;
        @(posedge clk);
        #1;
        md_flush = 1'b0;
        @(negedge clk);
        chk("flush_idle", {2'b0, hi, lo, md_busy, md_done}, {2'b0, mhi, mlo, 2'b00});
        md_go(2'b10, $urandom, 32'($urandom_range(1, 1000)), 1);
        wait_done(0);

        md_go(2'b00, $urandom, $urandom, 0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mhi = 32'd0;
        mlo = 32'd0;
        @(negedge clk);
        chk("reset_mid_run", {hi, lo, md_busy, md_done}, 66'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (md_done) nd++;
        end
        chk("no_done_after_reset", 66'(nd), 66'd0);

        hilo_wr = 2'b01;
        hilo_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        hilo_wr = 2'b00;
        mlo = 32'h1234_5678;
        @(negedge clk);
        chk("mtlo", {2'b0, hi, lo}, {2'b0, mhi, mlo});
        hilo_wr = 2'b10;
        hilo_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        hilo_wr = 2'b00;
        mhi = 32'hCAFE_F00D;
        @(negedge clk);
        chk("mthi", {2'b0, hi, lo}, {2'b0, mhi, mlo});

        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            md_go(rop, ra, rb, 1);
            wait_done(0);
        end
        repeat (3) @(negedge clk);
        chk("queue_drained", 66'(exp_q.size()), 66'd0);
        chk("final_hilo", {2'b0, hi, lo}, {2'b0, mhi, mlo});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
